// File: rtl/y_pattern_detector.sv
// Serial 1101 detector (Moore, overlapping) on the qualified Y stream of the upstream logic stage,
// with a registered match pulse, a saturating match counter and a sticky overflow flag.
module y_pattern_detector #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_in,
    input  logic             y_valid,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             overflow,
    output logic [2:0]       state_dbg
);

    localparam int unsigned STATE_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S11  = 3'd2,
        S110 = 3'd3,
        HIT  = 3'd4
    } state_t;

    state_t state;
    state_t state_next;
    logic   hit_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; illegal codes recover to IDLE regardless of y_valid
    always_comb begin
        state_next = state;
        hit_c      = 1'b0;
        case (state)
            IDLE: if (y_valid) state_next = y_in ? S1  : IDLE;
            S1:   if (y_valid) state_next = y_in ? S11 : IDLE;
            S11:  if (y_valid) state_next = y_in ? S11 : S110;
            S110: if (y_valid) state_next = y_in ? HIT : IDLE;
            HIT:  if (y_valid) state_next = y_in ? S11 : IDLE;
            default: state_next = IDLE;
        endcase
        hit_c = y_valid && (state_next == HIT);
    end

    // Match pulse, counter and sticky overflow; a clear concurrent with a match counts that match
    always_ff @(posedge clk) begin
        if (rst) begin
            match       <= 1'b0;
            match_count <= '0;
            overflow    <= 1'b0;
        end else begin
            match <= hit_c;
            if (clr_cnt) begin
                match_count <= hit_c ? CNT_W'(1) : '0;
                overflow    <= 1'b0;
            end else if (hit_c) begin
                if (match_count == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    match_count <= match_count + CNT_W'(1);
                end
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/y_pattern_detector.md
Name: y_pattern_detector

Overview:
- Downstream consumer of the single-bit combinational output Y of the preceding logic-circuit stage.
- Samples Y on qualified clock edges and runs a Moore FSM that detects the serial pattern 1101, with overlap allowed.
- Emits a one-cycle match pulse and keeps a saturating match counter with a sticky overflow flag.
- Gives the lab a sequential checker for the combinational stage's output stream.

Parameters:
- CNT_W, 4, width of match_count; the count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- y_in  input  1  serial data bit; connects to Y of the upstream logic stage.
- y_valid  input  1  y_in is consumed only on edges where y_valid=1.
- clr_cnt  input  1  synchronous clear of match_count and overflow; does not touch the FSM.
- match  output  1  registered one-cycle pulse; pattern completed on the previous edge.
- match_count  output  CNT_W  number of matches since reset or clear, saturating.
- overflow  output  1  sticky; set when a match occurs while match_count is at maximum.
- state_dbg  output  3  current FSM state encoding, for debug and bench visibility.

Behaviour:
- Reset values (rst=1 at an edge): state=IDLE, match=0, match_count=0, overflow=0.
- rst has priority over every other input.
- State encoding: IDLE=0, S1=1, S11=2, S110=3, HIT=4.
- Codes 5-7 are illegal; any illegal state goes to IDLE on the next edge and match=0.
- Transitions occur only on edges with y_valid=1. With y_valid=0 the state holds, match is 0, and the count holds.
- IDLE: y=1 -> S1; y=0 -> IDLE.
- S1: y=1 -> S11; y=0 -> IDLE.
- S11: y=1 -> S11; y=0 -> S110.
- S110: y=1 -> HIT; y=0 -> IDLE.
- HIT: y=1 -> S11; y=0 -> IDLE. The suffix "1" is reused, which gives overlapping detection.
- match: registered. match<=1 exactly on an edge with y_valid=1 where the next state is HIT; otherwise match<=0.
  - match is never high for two consecutive cycles, even when the FSM holds in HIT while y_valid=0.
  - Latency is 1 cycle: the edge that samples the final 1 of the pattern raises match, visible in the following cycle.
- Counter update happens on the same edge that sets match:
  - Below maximum: match_count increments by 1.
  - At maximum (2^CNT_W-1): match_count holds and overflow<=1.
  - overflow stays set until rst or clr_cnt.
- clr_cnt=1 with no match event on that edge: match_count<=0, overflow<=0.
- clr_cnt=1 and a match event on the same edge: match_count<=1, overflow<=0. The clear applies first and the concurrent match is counted.
- clr_cnt has no effect on state or match.
- Reset mid-pattern discards all partial progress. No match is reported for bits sampled before the reset.
- state_dbg is a direct copy of the state register.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset and overlap: rst for 2 cycles, then stream 1,1,0,1,1,0,1 with y_valid=1 each cycle -> match pulses after the 4th and 7th bits; match_count=2, overflow=0; state_dbg ends at 4.
- Self-loop in S11: stream 1,1,1,1,0,1 -> exactly one match, after the 6th bit; match_count=1.
- Valid gaps: bits 1,1,0,1 with y_valid=0 for 3 cycles between each bit -> state holds during gaps; single match; match high exactly 1 cycle although the FSM stays in HIT for 4 cycles.
- Reset mid-operation: stream 1,1,0, assert rst one cycle, then 1 -> state_dbg=1, no match, match_count=0.
- Saturation with CNT_W=4: 16 non-overlapping 1101 patterns -> match_count=15 and overflow=1 after the 16th; a 17th match leaves count at 15, overflow 1.
- Clear collisions:
  - clr_cnt asserted on the same edge as a match with count=9 -> count=1, overflow=0, match=1.
  - clr_cnt alone -> count=0, FSM state unchanged.
